// File: rtl/cpu_core_sc.sv
// cpu_core_sc: single-clock accumulator CPU core executing a 6502-encoded
// subset (LDA #/abs, ADC #, SBC #, STA abs, JMP abs, CLC, SEC, NOP).
// A fetch/decode FSM drives one memory request at a time. The request is held
// stable until the bus answers with mem_ready.
//
// Ports:
//   clk        single system clock, all state updates on the rising edge
//   rst        synchronous reset, active-high
//   mem_addr   access address (AW bits)
//   mem_rd     read request
//   mem_wr     write request, mutually exclusive with mem_rd
//   mem_wdata  write data, equal to AC during the STA write cycle, else 0
//   mem_rdata  read data, sampled on the edge where mem_ready=1
//   mem_ready  the pending access completes on this edge
//   sync       current request is an opcode fetch
//   ir_dbg     instruction register
//   ac_dbg     accumulator
//   pc_dbg     program counter
//   p_dbg      status {N,V,1,0,0,0,Z,C}
//   state_dbg  FSM state encoding
`timescale 1ns/1ps
module cpu_core_sc #(
    parameter int            DW       = 8,
    parameter int            AW       = 16,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          sync,
    output logic [7:0]    ir_dbg,
    output logic [DW-1:0] ac_dbg,
    output logic [AW-1:0] pc_dbg,
    output logic [7:0]    p_dbg,
    output logic [2:0]    state_dbg
);

    typedef enum logic [2:0] {
        S_RST   = 3'd0,
        S_FETCH = 3'd1,
        S_OP1   = 3'd2,
        S_OP2   = 3'd3,
        S_MRD   = 3'd4,
        S_MWR   = 3'd5,
        S_IMPL  = 3'd6
    } state_t;

    localparam logic [7:0] OP_LDA_IMM = 8'hA9;
    localparam logic [7:0] OP_LDA_ABS = 8'hAD;
    localparam logic [7:0] OP_ADC_IMM = 8'h69;
    localparam logic [7:0] OP_SBC_IMM = 8'hE9;
    localparam logic [7:0] OP_STA_ABS = 8'h8D;
    localparam logic [7:0] OP_JMP_ABS = 8'h4C;
    localparam logic [7:0] OP_CLC     = 8'h18;
    localparam logic [7:0] OP_SEC     = 8'h38;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] ac_q, ac_d;
    logic [7:0]    ir_q, ir_d;
    logic [DW-1:0] lo_q, lo_d;
    logic [DW-1:0] hi_q, hi_d;
    logic          n_q, n_d, v_q, v_d, z_q, z_d, c_q, c_d;

    logic [7:0]      opc;
    logic            has_operand;
    logic [2*DW-1:0] abs_full;
    logic [2*DW-1:0] jmp_full;
    logic [AW-1:0]   abs_addr;
    logic [AW-1:0]   jmp_addr;
    logic [DW-1:0]   alu_b;
    logic [DW:0]     alu_sum;
    logic            alu_v;

    assign opc      = mem_rdata[7:0];
    assign abs_full = {hi_q, lo_q};
    assign abs_addr = abs_full[AW-1:0];
    // JMP target uses the high byte straight off the bus, so it lands in the
    // same edge that would otherwise have latched hi.
    assign jmp_full = {mem_rdata, lo_q};
    assign jmp_addr = jmp_full[AW-1:0];

    // Only these six carry an operand; everything else (including unknown
    // encodings) falls into the implied path and behaves as a 2-cycle NOP.
    always_comb begin
        has_operand = 1'b0;
        case (opc)
            OP_LDA_IMM, OP_LDA_ABS, OP_ADC_IMM,
            OP_SBC_IMM, OP_STA_ABS, OP_JMP_ABS: has_operand = 1'b1;
            default:                            has_operand = 1'b0;
        endcase
    end

    // SBC is ADC of the one's complement; carry acts as not-borrow.
    assign alu_b   = (ir_q == OP_SBC_IMM) ? ~mem_rdata : mem_rdata;
    assign alu_sum = {1'b0, ac_q} + {1'b0, alu_b} + {{DW{1'b0}}, c_q};
    assign alu_v   = (ac_q[DW-1] == alu_b[DW-1]) && (alu_sum[DW-1] != ac_q[DW-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RST;
            pc_q    <= RESET_PC;
            ac_q    <= '0;
            ir_q    <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            n_q     <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ac_q    <= ac_d;
            ir_q    <= ir_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            n_q     <= n_d;
            v_q     <= v_d;
            z_q     <= z_d;
            c_q     <= c_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ac_d      = ac_q;
        ir_d      = ir_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        n_d       = n_q;
        v_d       = v_q;
        z_d       = z_q;
        c_d       = c_q;
        mem_addr  = '0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_wdata = '0;
        sync      = 1'b0;

        case (state_q)
            S_RST: state_d = S_FETCH;

            S_FETCH: begin
                mem_addr = pc_q;
                mem_rd   = 1'b1;
                sync     = 1'b1;
                if (mem_ready) begin
                    ir_d    = opc;
                    pc_d    = pc_q + 1'b1;
                    state_d = has_operand ? S_OP1 : S_IMPL;
                end
            end

            S_OP1: begin
                mem_addr = pc_q;
                mem_rd   = 1'b1;
                if (mem_ready) begin
                    lo_d = mem_rdata;
                    pc_d = pc_q + 1'b1;
                    case (ir_q)
                        OP_LDA_IMM: begin
                            ac_d    = mem_rdata;
                            n_d     = mem_rdata[DW-1];
                            z_d     = (mem_rdata == '0);
                            state_d = S_FETCH;
                        end
                        OP_ADC_IMM, OP_SBC_IMM: begin
                            ac_d    = alu_sum[DW-1:0];
                            c_d     = alu_sum[DW];
                            v_d     = alu_v;
                            n_d     = alu_sum[DW-1];
                            z_d     = (alu_sum[DW-1:0] == '0);
                            state_d = S_FETCH;
                        end
                        default: state_d = S_OP2;
                    endcase
                end
            end

            S_OP2: begin
                mem_addr = pc_q;
                mem_rd   = 1'b1;
                if (mem_ready) begin
                    hi_d = mem_rdata;
                    pc_d = pc_q + 1'b1;
                    case (ir_q)
                        OP_JMP_ABS: begin
                            pc_d    = jmp_addr;
                            state_d = S_FETCH;
                        end
                        OP_LDA_ABS: state_d = S_MRD;
                        default:    state_d = S_MWR;
                    endcase
                end
            end

            S_MRD: begin
                mem_addr = abs_addr;
                mem_rd   = 1'b1;
                if (mem_ready) begin
                    ac_d    = mem_rdata;
                    n_d     = mem_rdata[DW-1];
                    z_d     = (mem_rdata == '0);
                    state_d = S_FETCH;
                end
            end

            S_MWR: begin
                mem_addr  = abs_addr;
                mem_wr    = 1'b1;
                mem_wdata = ac_q;
                if (mem_ready) state_d = S_FETCH;
            end

            // No bus cycle here, so mem_ready is irrelevant.
            S_IMPL: begin
                if (ir_q == OP_CLC) c_d = 1'b0;
                if (ir_q == OP_SEC) c_d = 1'b1;
                state_d = S_FETCH;
            end

            default: state_d = S_FETCH;
        endcase
    end

    assign ir_dbg    = ir_q;
    assign ac_dbg    = ac_q;
    assign pc_dbg    = pc_q;
    assign p_dbg     = {n_q, v_q, 1'b1, 3'b000, z_q, c_q};
    assign state_dbg = state_q;

endmodule

// File: tb/tb_cpu_core_sc.sv
`timescale 1ns/1ps
module tb_cpu_core_sc;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] mem_addr;
    logic        mem_rd, mem_wr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        mem_ready;
    logic        sync;
    logic [7:0]  ir_dbg, ac_dbg, p_dbg;
    logic [15:0] pc_dbg;
    logic [2:0]  state_dbg;

    logic [7:0]  mem [0:65535];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          wr_cnt  = 0;
    int          overlap = 0;
    int          wr0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    cpu_core_sc #(.DW(8), .AW(16), .RESET_PC(16'h8000)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .sync      (sync),
        .ir_dbg    (ir_dbg),
        .ac_dbg    (ac_dbg),
        .pc_dbg    (pc_dbg),
        .p_dbg     (p_dbg),
        .state_dbg (state_dbg)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: the memory model commits any write that completes on this
    // edge, then outputs are sampled 1ns after the edge.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            if (mem_rd && mem_wr) overlap++;
            if (mem_wr && mem_ready && !rst) begin
                mem[mem_addr] = mem_wdata;
                wr_cnt++;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    endtask

    // Leaves the core in FETCH at 8000.
    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b1;
        step(3);
        rst = 1'b0;
        step(1);
    endtask

    initial begin
        rst = 1'b1;
        mem_ready = 1'b1;
        clear_mem();

        // 1: reset state
        step(3);
        check("rst_pc",    pc_dbg, 16'h8000);
        check("rst_p",     p_dbg, 8'h20);
        check("rst_rd",    mem_rd, 1'b0);
        check("rst_wr",    mem_wr, 1'b0);
        check("rst_state", state_dbg, 3'd0);
        check("rst_ac",    ac_dbg, 8'h00);
        rst = 1'b0;
        step(1);
        check("rel_sync",  sync, 1'b1);
        check("rel_addr",  mem_addr, 16'h8000);

        // 2: LDA #7F; ADC #01; SEC; SBC #80
        clear_mem();
        mem[16'h8000] = 8'hA9; mem[16'h8001] = 8'h7F;
        mem[16'h8002] = 8'h69; mem[16'h8003] = 8'h01;
        mem[16'h8004] = 8'h38;
        mem[16'h8005] = 8'hE9; mem[16'h8006] = 8'h80;
        do_reset();
        step(4);
        check("adc_ac",    ac_dbg, 8'h80);
        check("adc_p",     p_dbg, 8'hE0);
        step(2);
        check("sec_p",     p_dbg, 8'hE1);
        step(2);
        check("sbc_ac",    ac_dbg, 8'h00);
        check("sbc_p",     p_dbg, 8'h23);
        check("sbc_pc",    pc_dbg, 16'h8007);

        // 3: LDA #55; STA 1234; LDA #00; LDA 1234
        clear_mem();
        mem[16'h8000] = 8'hA9; mem[16'h8001] = 8'h55;
        mem[16'h8002] = 8'h8D; mem[16'h8003] = 8'h34; mem[16'h8004] = 8'h12;
        mem[16'h8005] = 8'hA9; mem[16'h8006] = 8'h00;
        mem[16'h8007] = 8'hAD; mem[16'h8008] = 8'h34; mem[16'h8009] = 8'h12;
        do_reset();
        step(2);
        check("lda55_ac",  ac_dbg, 8'h55);
        wr0 = wr_cnt;
        step(3);
        check("sta_state", state_dbg, 3'd5);
        check("sta_wr",    mem_wr, 1'b1);
        check("sta_rd",    mem_rd, 1'b0);
        check("sta_addr",  mem_addr, 16'h1234);
        check("sta_wdata", mem_wdata, 8'h55);
        step(1);
        check("sta_wr_off", mem_wr, 1'b0);
        check("sta_state2", state_dbg, 3'd1);
        check("sta_count", wr_cnt - wr0, 1);
        check("sta_mem",   mem[16'h1234], 8'h55);
        step(2);
        check("lda00_ac",  ac_dbg, 8'h00);
        check("lda00_p",   p_dbg, 8'h22);
        step(4);
        check("ldabs_ac",  ac_dbg, 8'h55);
        check("ldabs_p",   p_dbg, 8'h20);
        check("ldabs_pc",  pc_dbg, 16'h800A);

        // 4: JMP FFFF; NOP at FFFF wraps PC
        clear_mem();
        mem[16'h8000] = 8'h4C; mem[16'h8001] = 8'hFF; mem[16'h8002] = 8'hFF;
        mem[16'hFFFF] = 8'hEA;
        do_reset();
        step(3);
        check("jmp_pc",    pc_dbg, 16'hFFFF);
        check("jmp_sync",  sync, 1'b1);
        check("jmp_addr",  mem_addr, 16'hFFFF);
        step(1);
        check("wrap_pc",   pc_dbg, 16'h0000);
        check("nop_state", state_dbg, 3'd6);
        check("nop_rd",    mem_rd, 1'b0);
        step(1);
        check("wrap_addr", mem_addr, 16'h0000);

        // 5: STA 2000 with 3 wait states in OP2
        clear_mem();
        mem[16'h8000] = 8'hA9; mem[16'h8001] = 8'hAA;
        mem[16'h8002] = 8'h8D; mem[16'h8003] = 8'h00; mem[16'h8004] = 8'h20;
        do_reset();
        step(2);
        step(2);
        check("op2_state", state_dbg, 3'd3);
        mem_ready = 1'b0;
        step(3);
        check("stall_state", state_dbg, 3'd3);
        check("stall_addr",  mem_addr, 16'h8004);
        check("stall_rd",    mem_rd, 1'b1);
        check("stall_pc",    pc_dbg, 16'h8004);
        mem_ready = 1'b1;
        step(1);
        check("stall_mwr",   state_dbg, 3'd5);
        step(1);
        check("stall_done",  state_dbg, 3'd1);
        check("stall_pc2",   pc_dbg, 16'h8005);
        check("stall_mem",   mem[16'h2000], 8'hAA);

        // 6: reset during a stalled write, then unknown opcode 02
        clear_mem();
        mem[16'h8000] = 8'hA9; mem[16'h8001] = 8'h33;
        mem[16'h8002] = 8'h8D; mem[16'h8003] = 8'h00; mem[16'h8004] = 8'h30;
        do_reset();
        step(5);
        mem_ready = 1'b0;
        step(2);
        check("mwr_stall_state", state_dbg, 3'd5);
        check("mwr_stall_wr",    mem_wr, 1'b1);
        wr0 = wr_cnt;
        rst = 1'b1;
        step(1);
        check("abort_state", state_dbg, 3'd0);
        check("abort_pc",    pc_dbg, 16'h8000);
        check("abort_wr",    mem_wr, 1'b0);
        rst = 1'b0;
        mem[16'h8000] = 8'h38;
        mem[16'h8001] = 8'hA9; mem[16'h8002] = 8'hF0;
        mem[16'h8003] = 8'h02;
        mem_ready = 1'b1;
        step(1);
        check("abort_mem",   mem[16'h3000], 8'h00);
        check("abort_count", wr_cnt - wr0, 0);
        step(4);
        check("pre_ac",  ac_dbg, 8'hF0);
        check("pre_p",   p_dbg, 8'hA1);
        step(1);
        check("unk_state", state_dbg, 3'd6);
        step(1);
        check("unk_done",  state_dbg, 3'd1);
        check("unk_pc",    pc_dbg, 16'h8004);
        check("unk_ac",    ac_dbg, 8'hF0);
        check("unk_p",     p_dbg, 8'hA1);

        check("rd_wr_overlap", overlap, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
